// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the MEM-stage cache controller.
// Build option: define CACHE_EN to enable the data cache path.
package cache_controller_pkg;

  localparam int CACHE_ADDR_W = 17;
  localparam int LINE_W       = 64;
  localparam int WORD_W       = 32;
  localparam int CNT_W        = 3;

  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_FILL  = 3'd3,
    ST_WR    = 3'd4
  } state_t;

  function automatic logic [CACHE_ADDR_W-1:0] word_addr(
    input logic [31:0] a
  );
    return CACHE_ADDR_W'((a - DATA_MEM_BASE) >> 2);
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request bus between the pipeline and the cache controller.
// master = pipeline side, slave = controller side.
interface cache_controller_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, mem_addr, mem_wdata,
    input  mem_rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
    output mem_rdata, ready
  );

endinterface

// File: rtl/cache_controller_sram_wait_counter.sv
// Per-state SRAM access timer; last flags the final hold cycle.
// clear wins over enable so a new phase always starts at zero.
module sram_wait_counter
  import cache_controller_pkg::*;
#(
  parameter int SRAM_WAIT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      wait_cnt <= '0;
    else if (enable)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign last = (wait_cnt == CNT_W'(SRAM_WAIT - 1));

endmodule

// File: rtl/cache_controller.sv
// MEM-stage initiator: cache lookup, two-word line fill, write-through.
// Build option: CACHE_EN enables the cache; otherwise loads go to SRAM.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int SRAM_WAIT = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_controller_if.slave       bus,
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic [LINE_W-1:0]       cache_wdata,
  output logic                    cache_read_en,
  output logic                    cache_write_en,
  output logic                    cache_is_str,
  input  logic [WORD_W-1:0]       cache_rdata,
  input  logic                    cache_hit,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [CACHE_ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0]       sram_wdata,
  input  logic [WORD_W-1:0]       sram_rdata
);

  state_t state, nxt;

  logic [CACHE_ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0]       data_q;
  logic [WORD_W-1:0]       lo_q;
  logic [WORD_W-1:0]       hi_q;

  logic latch, lo_ld, hi_ld;
  logic last, in_sram, cnt_clr;

  assign cache_address = word_addr(bus.mem_addr);
  assign cache_wdata   = {hi_q, lo_q};

  assign in_sram = (state == ST_RD_LO) ||
                   (state == ST_RD_HI) ||
                   (state == ST_WR);
  assign cnt_clr = (state == ST_IDLE) || last;

  sram_wait_counter #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (in_sram),
    .last   (last)
  );

`ifndef CACHE_EN
  logic unused_cache;
  assign unused_cache = ^{cache_rdata, cache_hit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      state <= nxt;
      if (latch) begin
        addr_q <= cache_address;
        data_q <= bus.mem_wdata;
      end
      if (lo_ld) lo_q <= sram_rdata;
      if (hi_ld) hi_q <= sram_rdata;
    end
  end

  always_comb begin
    nxt            = state;
    bus.ready      = 1'b0;
    bus.mem_rdata  = '0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    cache_is_str   = 1'b0;
    sram_en        = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;
    latch          = 1'b0;
    lo_ld          = 1'b0;
    hi_ld          = 1'b0;

    unique case (state)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.mem_w_en) begin
`ifdef CACHE_EN
          cache_is_str = 1'b1;
`endif
          bus.ready = 1'b0;
          latch     = 1'b1;
          nxt       = ST_WR;
        end else if (bus.mem_r_en) begin
`ifdef CACHE_EN
          if (cache_hit) begin
            cache_read_en = 1'b1;
            bus.mem_rdata = cache_rdata;
          end else begin
            bus.ready = 1'b0;
            latch     = 1'b1;
            nxt       = ST_RD_LO;
          end
`else
          bus.ready = 1'b0;
          latch     = 1'b1;
          nxt       = ST_RD_LO;
`endif
        end
      end

      ST_RD_LO: begin
        sram_en = 1'b1;
`ifdef CACHE_EN
        sram_addr = {addr_q[CACHE_ADDR_W-1:1], 1'b0};
        if (last) begin
          lo_ld = 1'b1;
          nxt   = ST_RD_HI;
        end
`else
        sram_addr = addr_q;
        if (last) begin
          bus.ready     = 1'b1;
          bus.mem_rdata = sram_rdata;
          nxt           = ST_IDLE;
        end
`endif
      end

      ST_RD_HI: begin
`ifdef CACHE_EN
        sram_en   = 1'b1;
        sram_addr = {addr_q[CACHE_ADDR_W-1:1], 1'b1};
        if (last) begin
          hi_ld = 1'b1;
          nxt   = ST_FILL;
        end
`else
        nxt = ST_IDLE;
`endif
      end

      ST_FILL: begin
`ifdef CACHE_EN
        cache_write_en = 1'b1;
        bus.ready      = 1'b1;
        bus.mem_rdata  = addr_q[0] ? hi_q : lo_q;
`endif
        nxt = ST_IDLE;
      end

      ST_WR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = data_q;
        if (last) begin
          bus.ready = 1'b1;
          nxt       = ST_IDLE;
        end
      end

      default: nxt = ST_IDLE;
    endcase

    // Reset wins combinationally too: a half-done fill never reaches the cache.
    if (rst) begin
      bus.ready      = 1'b1;
      bus.mem_rdata  = '0;
      cache_read_en  = 1'b0;
      cache_write_en = 1'b0;
      cache_is_str   = 1'b0;
      sram_en        = 1'b0;
      sram_we        = 1'b0;
      sram_addr      = '0;
      sram_wdata     = '0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a word-level memory model.
// Expectations follow CACHE_EN the same way the design build does.
module tb_cache_controller;
  import cache_controller_pkg::*;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus ();

  logic [16:0] cache_address;
  logic [63:0] cache_wdata;
  logic        cache_read_en, cache_write_en, cache_is_str;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        sram_en, sram_we;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  cache_controller #(.SRAM_WAIT(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cache_address  (cache_address),
    .cache_wdata    (cache_wdata),
    .cache_read_en  (cache_read_en),
    .cache_write_en (cache_write_en),
    .cache_is_str   (cache_is_str),
    .cache_rdata    (cache_rdata),
    .cache_hit      (cache_hit),
    .sram_en        (sram_en),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata)
  );

  logic [31:0] sram_mem [64];
  assign sram_rdata = sram_mem[sram_addr[5:0]];
  always @(posedge clk)
    if (sram_en && sram_we) sram_mem[sram_addr[5:0]] <= sram_wdata;

`ifdef CACHE_EN
  logic [63:0] line_data  [32];
  logic        line_valid [32];
  assign cache_hit   = line_valid[cache_address[5:1]];
  assign cache_rdata = cache_address[0] ?
                       line_data[cache_address[5:1]][63:32] :
                       line_data[cache_address[5:1]][31:0];
  always @(posedge clk) begin
    if (cache_write_en) begin
      line_data[cache_address[5:1]]  <= cache_wdata;
      line_valid[cache_address[5:1]] <= 1'b1;
    end else if (cache_is_str) begin
      line_valid[cache_address[5:1]] <= 1'b0;
    end
  end
`else
  assign cache_hit   = 1'b1;
  assign cache_rdata = 32'hDEAD_BEEF;
`endif

  int wen_pulses = 0;
  always @(posedge clk) if (cache_write_en) wen_pulses <= wen_pulses + 1;

  logic [31:0] ref_mem   [64];
  bit          ref_valid [32];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit wr, input bit rd, input int w,
                        input logic [31:0] wd);
    int ln;
    int exp_lat;
    int exp_en;
    bit hit;
    int cyc;
    int n_en, n_we, n_ok, n_fill, n_rden, n_str;
    logic [63:0] fill_v;
    logic [31:0] got_rd;
    bit done;
    ln = w >> 1;
    hit = 1'b0;
    cyc = 0; n_en = 0; n_we = 0; n_ok = 0;
    n_fill = 0; n_rden = 0; n_str = 0;
    fill_v = '0; got_rd = '0; done = 1'b0;
    if (wr) begin
      exp_lat = W;
      exp_en  = W;
    end else begin
`ifdef CACHE_EN
      hit     = ref_valid[ln];
      exp_lat = hit ? 0 : 2 * W + 1;
      exp_en  = hit ? 0 : 2 * W;
`else
      exp_lat = W;
      exp_en  = W;
`endif
    end
    bus.mem_w_en  = wr;
    bus.mem_r_en  = rd;
    bus.mem_addr  = 32'd1024 + 32'(4 * w);
    bus.mem_wdata = wd;
    while (!done && cyc <= 4 * W + 8) begin
      #1;
      if (sram_en) n_en++;
      if (sram_en && sram_we) begin
        n_we++;
        if (sram_addr == 17'(w) && sram_wdata == wd) n_ok++;
      end
      if (sram_en && !sram_we) begin
`ifdef CACHE_EN
        if (sram_addr[16:1] == 16'(ln)) n_ok++;
`else
        if (sram_addr == 17'(w)) n_ok++;
`endif
      end
      if (cache_write_en) begin
        n_fill++;
        fill_v = cache_wdata;
      end
      if (cache_read_en) n_rden++;
      if (cache_is_str) n_str++;
      if (bus.ready) begin
        done   = 1'b1;
        got_rd = bus.mem_rdata;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("timeout", 64'(done), 64'd1);
    @(negedge clk);
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b0;
    chk(wr ? "st_latency" : "ld_latency", 64'(cyc), 64'(exp_lat));
    chk("sram_en_cycles", 64'(n_en), 64'(exp_en));
    chk("sram_addr_data_ok", 64'(n_ok), 64'(exp_en));
    chk("sram_we_cycles", 64'(n_we), wr ? 64'(W) : 64'd0);
    if (wr) begin
      ref_mem[w]    = wd;
      ref_valid[ln] = 1'b0;
`ifdef CACHE_EN
      chk("st_is_str", 64'(n_str), 64'd1);
`else
      chk("st_is_str", 64'(n_str), 64'd0);
`endif
      chk("st_fill", 64'(n_fill + n_rden), 64'd0);
    end else begin
      chk("ld_rdata", 64'(got_rd), 64'(ref_mem[w]));
      chk("ld_is_str", 64'(n_str), 64'd0);
`ifdef CACHE_EN
      chk("ld_read_en", 64'(n_rden), hit ? 64'd1 : 64'd0);
      chk("ld_fill_cnt", 64'(n_fill), hit ? 64'd0 : 64'd1);
      if (!hit)
        chk("ld_fill_line", fill_v,
            {ref_mem[w | 1], ref_mem[w & ~1]});
      ref_valid[ln] = 1'b1;
`else
      chk("ld_cache_en", 64'(n_fill + n_rden), 64'd0);
`endif
    end
  endtask

  initial begin
    int kind, w, ab, wp;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      sram_mem[i] <= v;
      ref_mem[i] = v;
    end
    sram_mem[2] <= 32'hAAAA_0001;
    sram_mem[3] <= 32'hBBBB_0002;
    ref_mem[2] = 32'hAAAA_0001;
    ref_mem[3] = 32'hBBBB_0002;
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
`ifdef CACHE_EN
    for (int i = 0; i < 32; i++) line_valid[i] <= 1'b0;
`endif

    rst           = 1'b1;
    bus.mem_r_en  = 1'b1;
    bus.mem_w_en  = 1'b1;
    bus.mem_addr  = 32'd1032;
    bus.mem_wdata = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_rdata", 64'(bus.mem_rdata), 64'd0);
    chk("rst_enables", 64'({sram_en, sram_we, cache_read_en,
        cache_write_en, cache_is_str}), 64'd0);
    chk("rst_sram_bus", 64'({sram_addr, sram_wdata}), 64'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    chk("idle_ready", 64'(bus.ready), 64'd1);
    chk("idle_sram_en", 64'(sram_en), 64'd0);
    @(negedge clk);

    // Abort a load partway; expect a clean return to idle.
`ifdef CACHE_EN
    ab = 8;
`else
    ab = 3;
`endif
    wp = wen_pulses;
    bus.mem_r_en = 1'b1;
    bus.mem_addr = 32'd1024 + 32'(4 * 10);
    repeat (ab) @(negedge clk);
    #1;
    chk("mid_ready", 64'(bus.ready), 64'd0);
    chk("mid_sram_en", 64'(sram_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_enables", 64'({sram_en, cache_write_en}), 64'd0);
    chk("abort_bus", 64'({sram_addr, bus.mem_rdata}), 64'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.mem_r_en = 1'b0;
    #1;
    chk("post_abort_ready", 64'(bus.ready), 64'd1);
    chk("post_abort_sram", 64'(sram_en), 64'd0);
    chk("abort_no_fill", 64'(wen_pulses), 64'(wp));
    @(negedge clk);

    do_req(1'b0, 1'b1, 10, 32'h0);
    do_req(1'b0, 1'b1, 2, 32'h0);
    do_req(1'b0, 1'b1, 3, 32'h0);
    do_req(1'b1, 1'b0, 2, 32'h1234_5678);
    do_req(1'b0, 1'b1, 2, 32'h0);
    do_req(1'b1, 1'b1, 3, 32'hCAFE_F00D);
    do_req(1'b0, 1'b1, 3, 32'h0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 15);
      v    = $urandom;
      if (kind < 4)      do_req(1'b1, 1'b0, w, v);
      else if (kind < 9) do_req(1'b0, 1'b1, w, v);
      else               do_req(1'b1, 1'b1, w, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Memory-stage initiator that sits between the ARM pipeline's MEM stage, the 2-way data cache and the external word SRAM. It converts pipeline load/store requests into cache lookups, line fills (two SRAM reads packed into one 64-bit cache write) and write-through SRAM stores. It freezes the pipeline through `ready` while an SRAM access is in flight.

## Interface
- `SRAM_WAIT`, default 5: cycles each SRAM access is held (≥1).
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_r_en` in 1: load request from MEM stage.
- `mem_w_en` in 1: store request from MEM stage.
- `mem_addr` in 32: byte address; data memory base 1024.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: load data, valid when `ready`=1 and `mem_r_en`=1.
- `ready` out 1: request completes this cycle; 0 = freeze pipeline.
- `cache_address` out 17: word address to cache (tag[16:7], index[6:1], offset[0]).
- `cache_wdata` out 64: fill line {odd word, even word}.
- `cache_read_en`, `cache_write_en`, `cache_is_str` out 1 each.
- `cache_rdata` in 32, `cache_hit` in 1: combinational cache response.
- `sram_en` out 1, `sram_we` out 1, `sram_addr` out 17, `sram_wdata` out 32, `sram_rdata` in 32.

## Operation
- Address: `cache_address` = ((mem_addr − 1024) >> 2)[16:0], combinational.
- States: IDLE, RD_LO, RD_HI, FILL, WR. 3-bit `wait_cnt` counts 0..SRAM_WAIT−1 inside each SRAM state, cleared on state entry.
- IDLE, no request: `ready`=1, all enables 0.
- IDLE, `mem_w_en` (priority over `mem_r_en` if both): `cache_is_str`=1 (cache invalidates on hit), `ready`=0, latch address/data, → WR.
- IDLE, `mem_r_en` & `cache_hit`: `cache_read_en`=1, `mem_rdata`=`cache_rdata`, `ready`=1, stay IDLE.
- IDLE, `mem_r_en` & !`cache_hit`: `ready`=0, → RD_LO.
- RD_LO: `sram_en`=1, `sram_addr`={addr[16:1],0}; at `wait_cnt`=SRAM_WAIT−1 latch `sram_rdata` into lo, → RD_HI.
- RD_HI: same with {addr[16:1],1}, latch hi, → FILL.
- FILL (one cycle): `cache_write_en`=1, `cache_wdata`={hi,lo}, `mem_rdata` = offset ? hi : lo, `ready`=1, → IDLE.
- WR: `sram_en`=1, `sram_we`=1, `sram_addr`=word address, `sram_wdata`=latched data; `ready`=1 at `wait_cnt`=SRAM_WAIT−1, → IDLE.
- Pipeline holds request stable while `ready`=0; controller uses latched address from IDLE exit onward.
- Reset (any state, incl. mid-fill/mid-write): next edge state=IDLE, `wait_cnt`=0, lo/hi/latched address/data=0; no cache write issued for an aborted fill. While `rst`=1 all cache/SRAM enables forced 0, `ready`=1, `mem_rdata`=0, `sram_addr`=0, `sram_wdata`=0.

## Timing
- Hit: 0 extra cycles (`ready`=1 in request cycle T0).
- Read miss: `ready`=0 T0..T(2W); `ready`=1 at T(2W+1) (W=5: T11). RD_LO T1..T5, RD_HI T6..T10, FILL T11.
- Store: `ready`=0 T0..T(W−1), `ready`=1 at TW (last WR cycle).
- `sram_rdata` sampled only on final cycle of each read phase.
- Request seen in the cycle after FILL/WR completes is a new request.

## Configuration
- `CACHE_EN` defined: behaviour above.
- Undefined: cache bypassed; all `cache_*` enables tied 0. Read: IDLE→RD_LO with `sram_addr`=word address, `mem_rdata`=`sram_rdata` and `ready`=1 on final RD_LO cycle, → IDLE (latency W). Store unchanged. RD_HI/FILL unreachable.

## Structure
- `defines.v`: state encodings, `DATA_MEM_BASE` (1024), `CACHE_ADDR_W` (17), `LINE_W` (64), `CACHE_EN`.
- Sub-module `sram_wait_counter`: parameterised by SRAM_WAIT, inputs clear/enable, output `last` (count = SRAM_WAIT−1).

## Test plan
- Reset in RD_HI (W=5, T8) → IDLE next edge, no `cache_write_en` pulse, `ready`=1 while `rst`=1.
- Load 1032, SRAM words 2/3 = 0xAAAA0001/0xBBBB0002 → `ready`=1 at T11, `mem_rdata`=0xAAAA0001, `cache_wdata`=0xBBBB0002_AAAA0001.
- Repeat load 1036 after fill with cache hit → `ready`=1 at T0, `cache_read_en`=1, `mem_rdata`=0xBBBB0002.
- Store 0x12345678 to 1032 → `cache_is_str`=1 at T0, `sram_we`=1 T1..T5, `sram_addr`=2, `ready`=1 at T5.
- `mem_r_en` & `mem_w_en` together → store path taken, no SRAM read.
- `CACHE_EN` undefined, load 1036 → `sram_addr`=3 for 5 cycles, `ready`=1 at T5, no cache enables.
